prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle RISC-V core's command memory. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into command memory through a dedicated write port, then verifies an XOR checksum. The core is held in reset until a load completes with a good checksum, and is then released.

---
 rtl/prog_loader.sv | 176 +++++++++++++++++
 tb/tb_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles little-endian instruction words from a byte
// stream, writes them into command memory, verifies an XOR checksum and releases the core.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  input  logic              i_reload,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_reg, state_next;
  logic [7:0]        len_lo_reg, len_lo_next;
  logic [ADDR_W:0]   n_reg, n_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [1:0]        lane_reg, lane_next;
  logic [23:0]       asm_reg, asm_next;
  logic [7:0]        xor_reg, xor_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              core_rst_n_reg, core_rst_n_next;

  logic              accept;
  logic [16:0]       len_ext;
  logic [ADDR_W:0]   cnt_inc;

  assign o_byte_ready = (state_reg != S_DONE) && (state_reg != S_ERR);
  assign o_busy       = o_byte_ready;
  assign accept       = i_byte_valid && o_byte_ready;
  assign len_ext      = {1'b0, i_byte, len_lo_reg};
  assign cnt_inc      = cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    len_lo_next     = len_lo_reg;
    n_next          = n_reg;
    cnt_next        = cnt_reg;
    lane_next       = lane_reg;
    asm_next        = asm_reg;
    xor_next        = xor_reg;
    we_next         = 1'b0;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    core_rst_n_next = core_rst_n_reg;

    case (state_reg)
      S_LEN0: begin
        if (accept) begin
          len_lo_next = i_byte;
          state_next  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          if (len_ext > MAX_WORDS) begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end else if (len_ext == 17'd0) begin
            state_next = S_CHK;
          end else begin
            n_next     = len_ext[ADDR_W:0];
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_next  = xor_reg ^ i_byte;
          lane_next = lane_reg + 2'd1;
          case (lane_reg)
            2'd0: asm_next[7:0]   = i_byte;
            2'd1: asm_next[15:8]  = i_byte;
            2'd2: asm_next[23:16] = i_byte;
            default: begin
              we_next    = 1'b1;
              wdata_next = {i_byte, asm_reg};
              addr_next  = cnt_reg[ADDR_W-1:0];
              cnt_next   = cnt_inc;
              // Counter is one bit wider than the address so a full memory load terminates
              if (cnt_inc == n_reg) state_next = S_CHK;
            end
          endcase
        end
      end
      S_CHK: begin
        if (accept) begin
          if (i_byte == xor_reg) begin
            state_next      = S_DONE;
            done_next       = 1'b1;
            core_rst_n_next = 1'b1;
          end else begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (i_reload) begin
          state_next      = S_LEN0;
          done_next       = 1'b0;
          err_next        = 1'b0;
          core_rst_n_next = 1'b0;
          cnt_next        = '0;
          lane_next       = '0;
          xor_next        = '0;
        end
      end
      default: state_next = S_LEN0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= S_LEN0;
      len_lo_reg     <= '0;
      n_reg          <= '0;
      cnt_reg        <= '0;
      lane_reg       <= '0;
      asm_reg        <= '0;
      xor_reg        <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      core_rst_n_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_lo_reg     <= len_lo_next;
      n_reg          <= n_next;
      cnt_reg        <= cnt_next;
      lane_reg       <= lane_next;
      asm_reg        <= asm_next;
      xor_reg        <= xor_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      core_rst_n_reg <= core_rst_n_next;
    end
  end

  assign o_imem_we    = we_reg;
  assign o_imem_addr  = addr_reg;
  assign o_imem_wdata = wdata_reg;
  assign o_done       = done_reg;
  assign o_err        = err_reg;
  assign o_core_rst_n = core_rst_n_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from word lists, the expected writes and result
// come from a frame-level model, and a monitor collects every memory write pulse.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int MAXW   = 1 << ADDR_W;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              o_byte_ready;
  logic              i_reload = 1'b0;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_core_rst_n, o_busy, o_done, o_err;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(o_byte_ready), .i_reload(i_reload), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_core_rst_n(o_core_rst_n),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] words_q[$];
  logic [7:0]  tx_q[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  logic        exp_ok;
  int          exp_acc;
  logic        prev_we = 1'b0;
  int          we_burst = 0;

  // Write monitor, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_imem_we) begin
      got_addr.push_back(int'(o_imem_addr));
      got_data.push_back(o_imem_wdata);
      if (prev_we) we_burst++;
    end
    prev_we = o_imem_we;
  end

  task automatic build_frame(input int n, input logic [7:0] mask);
    logic [7:0] x;
    logic [31:0] w;
    tx_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    if (n > MAXW) begin
      for (int k = 0; k < 4; k++) tx_q.push_back(8'($urandom));
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = words_q[k];
      for (int j = 0; j < 4; j++) begin
        tx_q.push_back(w[8*j +: 8]);
        x ^= w[8*j +: 8];
      end
    end
    tx_q.push_back(x ^ mask);
  endtask

  // Frame-level reference: parse the byte list as the protocol defines it
  task automatic model_frame();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    n = int'(tx_q[0]) + 256 * int'(tx_q[1]);
    if (n > MAXW) begin
      exp_ok  = 1'b0;
      exp_acc = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        w[8*j +: 8] = tx_q[2 + 4*k + j];
        x ^= tx_q[2 + 4*k + j];
      end
      exp_addr.push_back(k);
      exp_data.push_back(w);
    end
    exp_ok  = (tx_q[2 + 4*n] == x);
    exp_acc = 3 + 4*n;
  endtask

  task automatic run_frame(input string name, input bit gaps);
    int acc;
    int werr;
    got_addr.delete();
    got_data.delete();
    model_frame();
    acc = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          @(negedge i_clk);
          i_byte_valid = 1'b0;
          i_byte = 8'($urandom);
        end
      end
      @(negedge i_clk);
      if (!o_byte_ready) break;
      i_byte_valid = 1'b1;
      i_byte = tx_q[i];
      if (i == exp_acc - 1) begin
        total++;
        if (o_core_rst_n !== 1'b0) $display("FAIL %s core_rst_n_before_chk got=%b want=0", name, o_core_rst_n);
        else passed++;
      end
      @(posedge i_clk);
      acc++;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    total++;
    if (acc !== exp_acc) $display("FAIL %s accepted_bytes got=%0d want=%0d", name, acc, exp_acc);
    else passed++;
    total++;
    if (o_core_rst_n !== exp_ok) $display("FAIL %s core_rst_n got=%b want=%b", name, o_core_rst_n, exp_ok);
    else passed++;
    total++;
    if (o_done !== exp_ok || o_err !== !exp_ok)
      $display("FAIL %s done_err got=%b%b want=%b%b", name, o_done, o_err, exp_ok, !exp_ok);
    else passed++;
    total++;
    if (o_byte_ready !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL %s ready_busy got=%b%b want=00", name, o_byte_ready, o_busy);
    else passed++;
    repeat (2) @(negedge i_clk);
    total++;
    if (got_addr.size() !== exp_addr.size())
      $display("FAIL %s write_count got=%0d want=%0d", name, got_addr.size(), exp_addr.size());
    else passed++;
    werr = 0;
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      total++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        $display("FAIL %s write%0d got=%0d/%h want=%0d/%h", name, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
        werr++;
      end else passed++;
    end
    $display("frame %s: bytes=%0d writes=%0d done=%b err=%b", name, acc, got_addr.size(), o_done, o_err);
  endtask

  task automatic do_reload(input string name);
    @(negedge i_clk);
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    total++;
    if (o_err !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1 || o_byte_ready !== 1'b1 || o_core_rst_n !== 1'b0)
      $display("FAIL %s reload got err=%b done=%b busy=%b rdy=%b crst=%b want 0 0 1 1 0",
               name, o_err, o_done, o_busy, o_byte_ready, o_core_rst_n);
    else passed++;
    $display("reload %s", name);
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if (o_imem_we !== 1'b0 || o_imem_addr !== '0 || o_imem_wdata !== 32'h0 || o_core_rst_n !== 1'b0 ||
        o_done !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b1 || o_byte_ready !== 1'b1)
      $display("FAIL %s reset_outputs got we=%b addr=%h wd=%h crst=%b done=%b err=%b busy=%b rdy=%b",
               name, o_imem_we, o_imem_addr, o_imem_wdata, o_core_rst_n, o_done, o_err, o_busy, o_byte_ready);
    else passed++;
    $display("reset check %s", name);
  endtask

  task automatic test_reset();
    #2 i_rst = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    words_q = '{32'h00500093, 32'h00A00113};
    build_frame(2, 8'h00);
    run_frame("b2b", 1'b0);
    do_reload("b2b");
  endtask

  task automatic test_bad_chk();
    words_q = '{32'h00500093, 32'h00A00113};
    build_frame(2, 8'h01);
    run_frame("bad_chk", 1'b0);
    @(negedge i_clk);
    i_reload = 1'b0;
    total++;
    if (o_core_rst_n !== 1'b0 || o_byte_ready !== 1'b0)
      $display("FAIL bad_chk hold got crst=%b rdy=%b want 0 0", o_core_rst_n, o_byte_ready);
    else passed++;
    do_reload("bad_chk");
  endtask

  task automatic test_zero_len();
    words_q.delete();
    build_frame(0, 8'h00);
    run_frame("zero_ok", 1'b0);
    do_reload("zero_ok");
    build_frame(0, 8'h5A);
    run_frame("zero_bad", 1'b0);
    do_reload("zero_bad");
  endtask

  task automatic test_len_bounds();
    build_frame(MAXW + 1, 8'h00);
    run_frame("len_over", 1'b0);
    do_reload("len_over");
    words_q.delete();
    for (int k = 0; k < MAXW; k++) words_q.push_back($urandom);
    build_frame(MAXW, 8'h00);
    run_frame("len_max", 1'b0);
    do_reload("len_max");
  endtask

  task automatic test_gaps();
    words_q = '{32'h00500093, 32'h00A00113};
    build_frame(2, 8'h00);
    run_frame("gaps", 1'b1);
    do_reload("gaps");
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back($urandom);
      build_frame(n, ($urandom_range(2, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00);
      run_frame($sformatf("rand%0d", r), 1'b1);
      do_reload($sformatf("rand%0d", r));
    end
  endtask

  task automatic test_mid_reset();
    words_q = '{$urandom, $urandom};
    build_frame(2, 8'h00);
    for (int i = 0; i < 7; i++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte = tx_q[i];
      @(posedge i_clk);
    end
    #2 i_rst = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    words_q = '{$urandom, $urandom, $urandom};
    build_frame(3, 8'h00);
    run_frame("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bad_chk();
    test_zero_len();
    test_len_bounds();
    test_gaps();
    test_mid_reset();
    total++;
    if (we_burst !== 0) $display("FAIL we_spacing got=%0d back-to-back pulses want=0", we_burst);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
